// File: rtl/axis_rgb_word_packer.sv
// Repacks a stream of 24-bit RGB pixels into 32-bit little-endian words (4 pixels -> 3 words),
// with line tlast, start-of-frame tuser, upstream tlast framing check and a frame-done pulse.
module axis_rgb_word_packer #(
   parameter int CHANNEL_WIDTH  = 8,
   parameter int DST_IMG_WIDTH  = 3840,
   parameter int DST_IMG_HEIGHT = 2160
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       s_axis_tvalid,
   output logic                       s_axis_tready,
   input  logic [3*CHANNEL_WIDTH-1:0] s_axis_tdata,
   input  logic                       s_axis_tlast,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready,
   output logic [31:0]                m_axis_tdata,
   output logic [3:0]                 m_axis_tkeep,
   output logic                       m_axis_tlast,
   output logic                       m_axis_tuser,
   input  logic                       clear_err,
   output logic                       err_tlast,
   output logic                       frame_done
);

   localparam int COL_W = (DST_IMG_WIDTH > 1) ? $clog2(DST_IMG_WIDTH) : 1;
   localparam int ROW_W = (DST_IMG_HEIGHT > 1) ? $clog2(DST_IMG_HEIGHT) : 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(DST_IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(DST_IMG_HEIGHT - 1);

   logic [1:0]       phase;
   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic [23:0]      residue;
   logic [23:0]      residue_next;
   logic [31:0]      word_next;
   logic             word_valid;
   logic             out_valid;
   logic [31:0]      out_data;
   logic             out_last;
   logic             out_user;
   logic             out_frame_end;
   logic             err_q;
   logic             pix_acc;
   logic             col_is_last;

   // Valid/ready: a transfer happens on a rising edge where valid && ready; a producer holding
   // valid keeps its payload stable until that edge. Input ready frees up as soon as the single
   // output register is empty or draining this cycle.
   assign s_axis_tready = !out_valid || m_axis_tready;
   assign pix_acc       = s_axis_tvalid && s_axis_tready;
   assign col_is_last   = (col == COL_LAST);

   // Byte-lane splice: residue holds the bytes of earlier pixels not yet emitted.
   always_comb begin
      word_next    = '0;
      residue_next = residue;
      word_valid   = 1'b0;
      unique case (phase)
         2'd0: begin
            residue_next = s_axis_tdata;
         end
         2'd1: begin
            word_next    = {s_axis_tdata[7:0], residue};
            residue_next = {8'd0, s_axis_tdata[23:8]};
            word_valid   = 1'b1;
         end
         2'd2: begin
            word_next    = {s_axis_tdata[15:0], residue[15:0]};
            residue_next = {16'd0, s_axis_tdata[23:16]};
            word_valid   = 1'b1;
         end
         2'd3: begin
            word_next    = {s_axis_tdata, residue[7:0]};
            residue_next = '0;
            word_valid   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase   <= '0;
         col     <= '0;
         row     <= '0;
         residue <= '0;
      end else if (pix_acc) begin
         phase   <= phase + 2'd1;
         residue <= residue_next;
         if (col_is_last) begin
            col <= '0;
            row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
         end else begin
            col <= col + COL_W'(1);
         end
      end
   end

   // Reload wins over drain so full throughput needs no bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid     <= 1'b0;
         out_data      <= '0;
         out_last      <= 1'b0;
         out_user      <= 1'b0;
         out_frame_end <= 1'b0;
      end else if (pix_acc && word_valid) begin
         out_valid     <= 1'b1;
         out_data      <= word_next;
         out_last      <= col_is_last;
         out_user      <= (phase == 2'd1) && (col == COL_W'(1)) && (row == '0);
         out_frame_end <= col_is_last && (row == ROW_LAST);
      end else if (m_axis_tready) begin
         out_valid <= 1'b0;
      end
   end

   // Framing is always taken from the internal counters; a set beats a coincident clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (pix_acc && (s_axis_tlast != col_is_last)) begin
         err_q <= 1'b1;
      end else if (clear_err) begin
         err_q <= 1'b0;
      end
   end

   assign m_axis_tvalid = out_valid;
   assign m_axis_tdata  = out_data;
   assign m_axis_tkeep  = 4'hF;
   assign m_axis_tlast  = out_last;
   assign m_axis_tuser  = out_user;
   assign err_tlast     = err_q;
   assign frame_done    = out_valid && m_axis_tready && out_frame_end;

endmodule

// File: tb/tb_axis_rgb_word_packer.sv
// Bench for axis_rgb_word_packer at an 8x2 frame: directed table, backpressure, framing errors,
// randomized traffic against a byte-stream reference model, and mid-frame reset.
module tb_axis_rgb_word_packer;

   localparam int W     = 8;
   localparam int H     = 2;
   localparam int FRAME = W * H;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic [23:0] s_axis_tdata;
   logic        s_axis_tlast;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic [31:0] m_axis_tdata;
   logic [3:0]  m_axis_tkeep;
   logic        m_axis_tlast;
   logic        m_axis_tuser;
   logic        clear_err;
   logic        err_tlast;
   logic        frame_done;

   axis_rgb_word_packer #(
      .CHANNEL_WIDTH (8),
      .DST_IMG_WIDTH (W),
      .DST_IMG_HEIGHT(H)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready),
      .s_axis_tdata (s_axis_tdata),
      .s_axis_tlast (s_axis_tlast),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .m_axis_tdata (m_axis_tdata),
      .m_axis_tkeep (m_axis_tkeep),
      .m_axis_tlast (m_axis_tlast),
      .m_axis_tuser (m_axis_tuser),
      .clear_err    (clear_err),
      .err_tlast    (err_tlast),
      .frame_done   (frame_done)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- scoreboard state ----------------
   int          vec_count = 0;
   int          err_count = 0;
   logic [34:0] exp_q[$];          // {frame_end, user, last, data}
   logic [7:0]  byte_q[$];
   int          pix_n = 0;
   logic        exp_err = 1'b0;
   int          fd_count = 0;
   int          user_count = 0;
   int          word_count = 0;
   logic [34:0] exp_e;
   logic [7:0]  b0, b1, b2, b3;
   logic        mism;
   bit          bp_done;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_count++;
      if (act !== exp) begin
         err_count++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: pixels become a little-endian byte stream, every 4 bytes make a word.
   // Word attributes follow from the index of the pixel that completes it within its frame.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         byte_q.delete();
         pix_n   = 0;
         exp_err = 1'b0;
      end else begin
         if (m_axis_tvalid && m_axis_tready) begin
            word_count++;
            if (m_axis_tuser) user_count++;
            check("word_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               exp_e = exp_q.pop_front();
               check("word_data", m_axis_tdata, exp_e[31:0]);
               check("word_fd_user_last", {29'd0, frame_done, m_axis_tuser, m_axis_tlast},
                     {29'd0, exp_e[34:32]});
            end
         end else begin
            check("frame_done_idle", frame_done, 0);
         end
         if (frame_done) fd_count++;
         check("err_tlast", err_tlast, exp_err);
         check("tkeep", m_axis_tkeep, 4'hF);
         check("s_tready_rule", s_axis_tready, !m_axis_tvalid || m_axis_tready);

         if (s_axis_tvalid && s_axis_tready) begin
            mism = (s_axis_tlast != ((pix_n % W) == W - 1));
            byte_q.push_back(s_axis_tdata[7:0]);
            byte_q.push_back(s_axis_tdata[15:8]);
            byte_q.push_back(s_axis_tdata[23:16]);
            if (byte_q.size() >= 4) begin
               b0 = byte_q.pop_front();
               b1 = byte_q.pop_front();
               b2 = byte_q.pop_front();
               b3 = byte_q.pop_front();
               exp_q.push_back({pix_n == FRAME - 1, pix_n == 1, (pix_n % W) == W - 1,
                                b3, b2, b1, b0});
            end
            pix_n = (pix_n + 1) % FRAME;
            if (mism) exp_err = 1'b1;
            else if (clear_err) exp_err = 1'b0;
         end else if (clear_err) begin
            exp_err = 1'b0;
         end
      end
   end

   // ---------------- driver tasks (all inputs change at posedge + 1) ----------------
   task automatic wait_accept();
      bit accepted = 1'b0;
      for (int i = 0; i < 2000 && !accepted; i++) begin
         @(negedge clk);
         if (s_axis_tready) accepted = 1'b1;
      end
      check("pixel_accept", accepted, 1);
      @(posedge clk); #1;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic send_pixel(input logic [23:0] pix, input logic last, input int max_gap);
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (gap) begin @(posedge clk); #1; end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = pix;
      s_axis_tlast  = last;
      wait_accept();
   endtask

   task automatic send_pixels(input int start, input int count, input int max_gap);
      logic [31:0] r;
      int idx;
      for (int i = 0; i < count; i++) begin
         idx = (start + i) % FRAME;
         r   = $urandom;
         send_pixel(r[23:0], (idx % W) == W - 1, max_gap);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic check_reset_outputs();
      check("rst_m_tvalid", m_axis_tvalid, 0);
      check("rst_s_tready", s_axis_tready, 1);
      check("rst_tkeep", m_axis_tkeep, 4'hF);
      check("rst_tdata", m_axis_tdata, 0);
      check("rst_tlast", m_axis_tlast, 0);
      check("rst_tuser", m_axis_tuser, 0);
      check("rst_err", err_tlast, 0);
      check("rst_frame_done", frame_done, 0);
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic [23:0] pix;
      logic        last_in;
      logic        has_word;
      logic [31:0] word;
      logic        w_last;
      logic        w_user;
   } vec_t;

   vec_t tbl[8];
   int   fd0;
   int   wc0;
   int   uc0;

   initial begin
      tbl[0] = '{24'h030201, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0};
      tbl[1] = '{24'h060504, 1'b0, 1'b1, 32'h04030201, 1'b0, 1'b1};
      tbl[2] = '{24'h090807, 1'b0, 1'b1, 32'h08070605, 1'b0, 1'b0};
      tbl[3] = '{24'h0C0B0A, 1'b0, 1'b1, 32'h0C0B0A09, 1'b0, 1'b0};
      tbl[4] = '{24'h0F0E0D, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0};
      tbl[5] = '{24'h121110, 1'b0, 1'b1, 32'h100F0E0D, 1'b0, 1'b0};
      tbl[6] = '{24'h151413, 1'b0, 1'b1, 32'h14131211, 1'b0, 1'b0};
      tbl[7] = '{24'h181716, 1'b1, 1'b1, 32'h18171615, 1'b1, 1'b0};

      rst_n         = 1'b0;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tlast  = 1'b0;
      m_axis_tready = 1'b1;
      clear_err     = 1'b0;
      bp_done       = 1'b0;
      idle(3);
      check_reset_outputs();
      rst_n = 1'b1;
      idle(2);

      // Line 0 of frame 0 from the table, full downstream throughput.
      for (int i = 0; i < 8; i++) begin
         send_pixel(tbl[i].pix, tbl[i].last_in, 0);
         check("tbl_valid", m_axis_tvalid, tbl[i].has_word);
         if (tbl[i].has_word) begin
            check("tbl_data", m_axis_tdata, tbl[i].word);
            check("tbl_last_user", {m_axis_tlast, m_axis_tuser}, {tbl[i].w_last, tbl[i].w_user});
         end
      end

      // Finish frame 0, then one complete frame: 12 words, one frame_done.
      fd0 = fd_count;
      send_pixels(8, 8, 0);
      idle(3);
      check("frame0_done_pulses", fd_count - fd0, 1);
      fd0 = fd_count;
      wc0 = word_count;
      send_pixels(0, FRAME, 0);
      idle(3);
      check("frame1_words", word_count - wc0, 12);
      check("frame1_done_pulses", fd_count - fd0, 1);
      check("frame1_err", err_tlast, 0);

      // Output stall after the first word of a frame.
      m_axis_tready = 1'b0;
      send_pixel(24'h030201, 1'b0, 0);
      send_pixel(24'h060504, 1'b0, 0);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 24'h090807;
      s_axis_tlast  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("stall_s_tready", s_axis_tready, 0);
         check("stall_valid", m_axis_tvalid, 1);
         check("stall_data", m_axis_tdata, 32'h04030201);
         check("stall_user", m_axis_tuser, 1);
         idle(1);
      end
      m_axis_tready = 1'b1;
      wait_accept();
      send_pixels(3, FRAME - 3, 0);
      idle(3);

      // Framing errors: early tlast, sticky, clear, and set beating clear.
      send_pixels(0, 3, 0);
      send_pixel(24'hABCDEF, 1'b1, 0);
      check("err_set", err_tlast, 1);
      send_pixels(4, 4, 0);
      check("err_sticky", err_tlast, 1);
      clear_err = 1'b1;
      idle(1);
      clear_err = 1'b0;
      check("err_cleared", err_tlast, 0);
      send_pixels(8, 3, 0);
      clear_err = 1'b1;
      send_pixel(24'h123456, 1'b1, 0);
      clear_err = 1'b0;
      check("err_set_beats_clear", err_tlast, 1);
      clear_err = 1'b1;
      idle(1);
      clear_err = 1'b0;
      check("err_cleared_again", err_tlast, 0);
      send_pixels(12, 4, 0);
      idle(3);

      // Random backpressure over three frames.
      fd0 = fd_count;
      uc0 = user_count;
      fork
         begin
            send_pixels(0, 3 * FRAME, 3);
            bp_done = 1'b1;
         end
         begin
            while (!bp_done) begin
               @(posedge clk); #1;
               m_axis_tready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      m_axis_tready = 1'b1;
      idle(5);
      check("rand_frame_done_pulses", fd_count - fd0, 3);
      check("rand_tuser_words", user_count - uc0, 3);
      check("rand_queue_drained", exp_q.size(), 0);

      // Reset in the middle of a frame.
      send_pixels(0, 5, 0);
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      idle(2);
      check_reset_outputs();
      rst_n = 1'b1;
      idle(1);
      send_pixel(24'h030201, 1'b0, 0);
      send_pixel(24'h060504, 1'b0, 0);
      check("post_rst_valid", m_axis_tvalid, 1);
      check("post_rst_data", m_axis_tdata, 32'h04030201);
      check("post_rst_user", m_axis_tuser, 1);
      fd0 = fd_count;
      send_pixels(2, FRAME - 2, 0);
      idle(5);
      check("post_rst_frame_done", fd_count - fd0, 1);
      check("final_queue_drained", exp_q.size(), 0);
      check("final_err", err_tlast, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
      $finish;
   end

endmodule
